// File: rtl/button_deb_pkg.sv
// Shared defaults and the consumer-facing event type for the button debouncer.
package button_deb_pkg;

    localparam int unsigned DEB_CYCLES_DEF  = 50000;
    localparam int unsigned LONG_CYCLES_DEF = 8000000;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_LONG    = 2'd3
    } btn_evt_e;

endpackage

// File: rtl/button_deb_chan.sv
// One debounced button channel: 2-flop synchroniser, stability counter, edge pulses.
// Long-press counter and long_p exist only when BUTTON_DEB_LONGPRESS_EN is defined.
module button_deb_chan
    import button_deb_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
`ifdef BUTTON_DEB_LONGPRESS_EN
    parameter int unsigned LONG_W      = 24,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
`endif
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic valid,
    output logic press_p,
    output logic release_p
`ifdef BUTTON_DEB_LONGPRESS_EN
    ,
    output logic long_p
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw;

    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
        raw     = sync2_q ^ ACTIVE_LOW;
        valid_d = valid_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        // any cycle of agreement restarts the stability window
        if (raw == valid_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            valid_d = raw;
            cnt_d   = '0;
            press_d = raw;
            rel_d   = ~raw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            valid_q <= valid_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid     = valid_q;
    assign press_p   = press_q;
    assign release_p = rel_q;

`ifdef BUTTON_DEB_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LCNT_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LCNT_SAT  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] lcnt_q, lcnt_d;
    logic              long_q, long_d;

    // Saturating one past the fire value guarantees a single pulse per press.
    always_comb begin
        lcnt_d = '0;
        long_d = 1'b0;
        if (valid_q) begin
            long_d = (lcnt_q == LCNT_LAST);
            lcnt_d = (lcnt_q == LCNT_SAT) ? lcnt_q : lcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign long_p = long_q;
`endif

endmodule

// File: rtl/button_deb_multi.sv
// N-channel button debouncer: independent debounce per pin, level plus press/release pulses.
// Define BUTTON_DEB_LONGPRESS_EN to add per-channel long-press detection and the long_p port.
module button_deb_multi
    import button_deb_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned LONG_W      = 24,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] button_valid,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p
`ifdef BUTTON_DEB_LONGPRESS_EN
    ,
    output logic [N_CH-1:0] long_p
`endif
);

    if (N_CH < 1) begin : g_bad_nch
        $error("button_deb_multi: N_CH must be at least 1");
    end
    if (DEB_CYCLES < 1 || 64'(DEB_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_deb
        $error("button_deb_multi: DEB_CYCLES does not fit CNT_W");
    end
    if (LONG_CYCLES < 1 || 64'(LONG_CYCLES) >= (64'd1 << LONG_W)) begin : g_bad_long
        $error("button_deb_multi: LONG_CYCLES does not fit LONG_W");
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        button_deb_chan #(
            .CNT_W       (CNT_W),
            .DEB_CYCLES  (DEB_CYCLES),
`ifdef BUTTON_DEB_LONGPRESS_EN
            .LONG_W      (LONG_W),
            .LONG_CYCLES (LONG_CYCLES),
`endif
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .pin_in    (button_in[i]),
            .valid     (button_valid[i]),
            .press_p   (press_p[i]),
            .release_p (release_p[i])
`ifdef BUTTON_DEB_LONGPRESS_EN
            ,
            .long_p    (long_p[i])
`endif
        );
    end

endmodule

// File: tb/tb_button_deb_multi.sv
// Bench for button_deb_multi: table of pin phases with per-edge expectations via a scoreboard,
// plus hand sequences for reset, long press and the active-low variant.
module tb_button_deb_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] btn_al = 2'b11;
    logic [1:0] valid, press, rel;
    logic [1:0] valid_al, press_al, rel_al;
`ifdef BUTTON_DEB_LONGPRESS_EN
    logic [1:0] lng, lng_al;
`endif

    button_deb_multi #(
        .N_CH(2), .CNT_W(16), .DEB_CYCLES(4), .LONG_W(24), .LONG_CYCLES(10), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .button_in(btn),
        .button_valid(valid), .press_p(press), .release_p(rel)
`ifdef BUTTON_DEB_LONGPRESS_EN
        , .long_p(lng)
`endif
    );

    button_deb_multi #(
        .N_CH(2), .CNT_W(16), .DEB_CYCLES(4), .LONG_W(24), .LONG_CYCLES(10), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .button_in(btn_al),
        .button_valid(valid_al), .press_p(press_al), .release_p(rel_al)
`ifdef BUTTON_DEB_LONGPRESS_EN
        , .long_p(lng_al)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] btn;
        int         hold;
        int         ev_edge;      // edge within this phase where the event lands, 0 = none
        logic [1:0] valid_after;
        logic [1:0] press_m;
        logic [1:0] rel_m;
    } vec_t;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] press;
        logic [1:0] rel;
        string      tag;
    } exp_t;

    vec_t vecs[21];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic vec_t mk(logic [1:0] b, int h, int ev, logic [1:0] v, logic [1:0] p, logic [1:0] r);
        vec_t x;
        x.btn = b; x.hold = h; x.ev_edge = ev; x.valid_after = v; x.press_m = p; x.rel_m = r;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev;
        exp_t       x;
        bit         seen;

        // clean presses, simultaneity, sub-window glitch, exact-window pulse, bounce
        vecs[0] = mk(2'b00, 8, 0, 2'b00, 2'b00, 2'b00);
        vecs[1] = mk(2'b01, 8, 6, 2'b01, 2'b01, 2'b00);
        vecs[2] = mk(2'b11, 8, 6, 2'b11, 2'b10, 2'b00);
        vecs[3] = mk(2'b00, 8, 6, 2'b00, 2'b00, 2'b11);
        vecs[4] = mk(2'b01, 3, 0, 2'b00, 2'b00, 2'b00);
        vecs[5] = mk(2'b00, 6, 0, 2'b00, 2'b00, 2'b00);
        vecs[6] = mk(2'b01, 4, 0, 2'b00, 2'b00, 2'b00);
        vecs[7] = mk(2'b00, 3, 2, 2'b01, 2'b01, 2'b00);
        vecs[8] = mk(2'b00, 8, 3, 2'b00, 2'b00, 2'b01);
        for (int k = 0; k < 10; k++)
            vecs[9+k] = mk((k % 2 == 0) ? 2'b01 : 2'b00, 2, 0, 2'b00, 2'b00, 2'b00);
        vecs[19] = mk(2'b01, 8, 6, 2'b01, 2'b01, 2'b00);
        vecs[20] = mk(2'b00, 8, 6, 2'b00, 2'b00, 2'b01);

        // reset state
        rst = 1'b1;
        repeat (3) step();
        chk("reset valid", {6'd0, valid}, 8'h0);
        chk("reset press", {6'd0, press}, 8'h0);
        chk("reset release", {6'd0, rel}, 8'h0);
        chk("reset al valid", {6'd0, valid_al}, 8'h0);
        rst = 1'b0;

        prev = 2'b00;
        for (int i = 0; i < 21; i++) begin
            btn = vecs[i].btn;
            for (int e = 1; e <= vecs[i].hold; e++) begin
                x.tag   = $sformatf("v%0d e%0d", i, e);
                x.valid = (vecs[i].ev_edge != 0 && e >= vecs[i].ev_edge) ? vecs[i].valid_after : prev;
                x.press = (e == vecs[i].ev_edge) ? vecs[i].press_m : 2'b00;
                x.rel   = (e == vecs[i].ev_edge) ? vecs[i].rel_m : 2'b00;
                sb.push_back(x);
            end
            for (int e = 1; e <= vecs[i].hold; e++) begin
                step();
                x = sb.pop_front();
                chk({x.tag, " valid"}, {6'd0, valid}, {6'd0, x.valid});
                chk({x.tag, " press"}, {6'd0, press}, {6'd0, x.press});
                chk({x.tag, " release"}, {6'd0, rel}, {6'd0, x.rel});
            end
            if (vecs[i].ev_edge != 0) prev = vecs[i].valid_after;
        end
        chk("al idle valid", {6'd0, valid_al}, 8'h0);

        // mid-cycle asynchronous reset while both channels pressed
        btn = 2'b11;
        seen = 1'b0;
        for (int e = 0; e < 20 && !seen; e++) begin
            step();
            if (valid == 2'b11) seen = 1'b1;
        end
        chk("pre-reset press reached", {7'd0, seen}, 8'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async reset valid", {6'd0, valid}, 8'h0);
        chk("async reset press", {6'd0, press}, 8'h0);
        chk("async reset release", {6'd0, rel}, 8'h0);
        #6;
        #1;
        chk("held reset valid", {6'd0, valid}, 8'h0);
        #3 rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("post-reset e%0d press", e), {6'd0, press}, (e == 6) ? 8'h3 : 8'h0);
            chk($sformatf("post-reset e%0d valid", e), {6'd0, valid}, (e >= 6) ? 8'h3 : 8'h0);
        end
        btn = 2'b00;
        repeat (10) step();
        chk("release before idle reset", {6'd0, valid}, 8'h0);

        // reset with inputs idle keeps everything quiet
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("idle e%0d outputs", e), {2'd0, valid, press, rel}, 8'h0);
        end

`ifdef BUTTON_DEB_LONGPRESS_EN
        // long press on ch1: valid rises on edge 6, long_p on edge 16, never again while held
        btn = 2'b10;
        for (int e = 1; e <= 40; e++) begin
            step();
            chk($sformatf("long e%0d long_p", e), {6'd0, lng}, (e == 16) ? 8'h2 : 8'h0);
            if (e == 6) chk("long press_p", {6'd0, press}, 8'h2);
        end
        btn = 2'b00;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("long release e%0d long_p", e), {6'd0, lng}, 8'h0);
        end
`endif

        // active-low variant: ch0 pin driven low is a press
        chk("al valid before press", {6'd0, valid_al}, 8'h0);
        btn_al = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("al e%0d press", e), {6'd0, press_al}, (e == 6) ? 8'h1 : 8'h0);
        end
        chk("al valid pressed", {6'd0, valid_al}, 8'h1);
        btn_al = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("al e%0d release", e), {6'd0, rel_al}, (e == 6) ? 8'h1 : 8'h0);
        end
        chk("al valid released", {6'd0, valid_al}, 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
